// File: rtl/prbs6_checker.sv
// Self-synchronising checker for the 6-bit PRBS generator state word.
// Searches, verifies LOCK_CNT predictions, then free-runs a reference and counts mismatches.
module prbs6_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int DATA_W = 6;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);
  localparam logic [DATA_W-1:0] REF_SEED = 6'h3F;

  function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] s);
    return {s[5] ^ s[4], s[5] ^ s[3], s[2], s[5] ^ s[1], s[0], s[5]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] one;
    one = {{(ERR_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_ref;
  logic [3:0]        r_match_cnt;
  logic [3:0]        r_miss_cnt;
  logic              r_locked;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;

  logic [DATA_W-1:0] w_expect;
  logic              w_in_zero;
  logic              w_hit;
  logic [3:0]        w_match_inc;
  logic [3:0]        w_miss_inc;
  logic              w_err;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_ref_nxt;
  logic [3:0]        w_match_nxt;
  logic [3:0]        w_miss_nxt;

  assign w_expect    = prbs_next(r_ref);
  assign w_in_zero   = (in_data == '0);
  assign w_hit       = (in_data == w_expect);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;
  assign w_err       = in_valid && (r_state == ST_LOCKED) && !w_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    if (in_valid) begin
      case (r_state)
        ST_SEARCH: begin
          if (!w_in_zero) begin
            w_ref_nxt   = in_data;
            w_match_nxt = 4'd0;
            w_state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          w_ref_nxt = in_data;
          if (w_hit) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_TGT) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = 4'd0;
            end
          end else begin
            w_match_nxt = 4'd0;
            if (w_in_zero) w_state_nxt = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Reference free-runs; the input never reseeds it once locked.
          w_ref_nxt = w_expect;
          if (w_hit) begin
            w_miss_nxt = 4'd0;
          end else if (w_miss_inc == UNLOCK_TGT) begin
            w_miss_nxt  = 4'd0;
            w_match_nxt = 4'd0;
            w_state_nxt = ST_SEARCH;
          end else begin
            w_miss_nxt = w_miss_inc;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_match_nxt = 4'd0;
          w_miss_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SEARCH;
      r_ref       <= REF_SEED;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref       <= w_ref_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err;
      // Clear has priority over a coincident error increment.
      if (clr_err)    r_err_count <= '0;
      else if (w_err) r_err_count <= sat_inc(r_err_count);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs6_checker.sv
// Directed bench for prbs6_checker: lock, single error, unlock/relock, gaps,
// saturation with clear (ERR_W=2 instance), async reset and zero-word handling.
module tb_prbs6_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_data;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  logic        s_valid;
  logic [5:0]  s_data;
  logic        s_clr;
  logic        s_locked;
  logic        s_err_pulse;
  logic [1:0]  s_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed generator chain starting at 3F.
  logic [5:0] seq [21] = '{6'h3F, 6'h0B, 6'h16, 6'h2C, 6'h2D, 6'h2F, 6'h2B, 6'h23,
                          6'h33, 6'h13, 6'h26, 6'h39, 6'h07, 6'h0E, 6'h1C, 6'h38,
                          6'h05, 6'h0A, 6'h14, 6'h28, 6'h25};

  prbs6_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs6_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_data(s_data),
    .clr_err(s_clr), .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [5:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [5:0] d, input logic c);
    s_valid = v;
    s_data  = d;
    s_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (locked !== 1'b0) begin
      $display("FAIL reset_locked actual=%0b required=0", locked); n_fail++;
    end
    n_tests++;
    if (err_pulse !== 1'b0) begin
      $display("FAIL reset_err_pulse actual=%0b required=0", err_pulse); n_fail++;
    end
    n_tests++;
    if (err_count !== 16'd0) begin
      $display("FAIL reset_err_count actual=%0d required=0", err_count); n_fail++;
    end
    reset = 1'b1;
  endtask

  task automatic test_lock;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i]);
      n_tests++;
      if (locked !== (i == 4)) begin
        $display("FAIL lock_step%0d actual=%0b required=%0b", i, locked, (i == 4)); n_fail++;
      end
    end
    drive(1'b0, 6'h00);
    n_tests++;
    if (err_count !== 16'd0) begin
      $display("FAIL lock_err_count actual=%0d required=0", err_count); n_fail++;
    end
  endtask

  task automatic test_single_error;
    drive(1'b1, 6'h00);
    n_tests++;
    if (err_pulse !== 1'b1) begin
      $display("FAIL single_pulse actual=%0b required=1", err_pulse); n_fail++;
    end
    n_tests++;
    if (err_count !== 16'd1) begin
      $display("FAIL single_count actual=%0d required=1", err_count); n_fail++;
    end
    n_tests++;
    if (locked !== 1'b1) begin
      $display("FAIL single_locked actual=%0b required=1", locked); n_fail++;
    end
    for (int i = 6; i <= 10; i++) begin
      drive(1'b1, seq[i]);
      n_tests++;
      if (err_pulse !== 1'b0) begin
        $display("FAIL single_after%0d_pulse actual=%0b required=0", i, err_pulse); n_fail++;
      end
    end
    n_tests++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      $display("FAIL single_final actual=%0d/%0b required=1/1", err_count, locked); n_fail++;
    end
  endtask

  task automatic test_unlock;
    logic [5:0] bad [3];
    bad = '{6'h00, 6'h15, 6'h3F};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i]);
      n_tests++;
      if (err_pulse !== 1'b1) begin
        $display("FAIL unlock_pulse%0d actual=%0b required=1", i, err_pulse); n_fail++;
      end
      n_tests++;
      if (err_count !== 16'(2 + i)) begin
        $display("FAIL unlock_count%0d actual=%0d required=%0d", i, err_count, 2 + i); n_fail++;
      end
      n_tests++;
      if (locked !== (i != 2)) begin
        $display("FAIL unlock_locked%0d actual=%0b required=%0b", i, locked, (i != 2)); n_fail++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i]);
      n_tests++;
      if (locked !== (i == 4) || err_pulse !== 1'b0) begin
        $display("FAIL relock_step%0d actual=%0b/%0b required=%0b/0", i, locked, err_pulse, (i == 4));
        n_fail++;
      end
    end
    n_tests++;
    if (err_count !== 16'd4) begin
      $display("FAIL relock_count actual=%0d required=4", err_count); n_fail++;
    end
  endtask

  task automatic test_gaps;
    for (int i = 5; i <= 14; i++) begin
      drive(1'b1, seq[i]);
      n_tests++;
      if (err_pulse !== 1'b0 || locked !== 1'b1) begin
        $display("FAIL gaps_valid%0d actual=%0b/%0b required=0/1", i, err_pulse, locked); n_fail++;
      end
      drive(1'b0, 6'h2A);
      n_tests++;
      if (err_pulse !== 1'b0 || locked !== 1'b1) begin
        $display("FAIL gaps_idle%0d actual=%0b/%0b required=0/1", i, err_pulse, locked); n_fail++;
      end
    end
    n_tests++;
    if (err_count !== 16'd4) begin
      $display("FAIL gaps_count actual=%0d required=4", err_count); n_fail++;
    end
  endtask

  task automatic test_reset_zero;
    drive(1'b1, 6'h00);
    n_tests++;
    if (err_count !== 16'd5 || locked !== 1'b1) begin
      $display("FAIL rz_pre actual=%0d/%0b required=5/1", err_count, locked); n_fail++;
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0 || err_count !== 16'd0) begin
      $display("FAIL rz_async actual=%0b/%0d required=0/0", locked, err_count); n_fail++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'h00);
      n_tests++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
        $display("FAIL rz_zero%0d actual=%0b/%0b/%0d required=0/0/0", i, locked, err_pulse, err_count);
        n_fail++;
      end
    end
    for (int i = 0; i < 5; i++) drive(1'b1, seq[i]);
    n_tests++;
    if (locked !== 1'b1) begin
      $display("FAIL rz_relock actual=%0b required=1", locked); n_fail++;
    end
  endtask

  task automatic test_clear;
    drive(1'b1, 6'h00);
    n_tests++;
    if (err_count !== 16'd1) begin
      $display("FAIL clear_pre actual=%0d required=1", err_count); n_fail++;
    end
    clr_err = 1'b1;
    drive(1'b0, 6'h00);
    clr_err = 1'b0;
    n_tests++;
    if (err_count !== 16'd0 || locked !== 1'b1 || err_pulse !== 1'b0) begin
      $display("FAIL clear_idle actual=%0d/%0b/%0b required=0/1/0", err_count, locked, err_pulse);
      n_fail++;
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) drive_s(1'b1, seq[i], 1'b0);
    n_tests++;
    if (s_locked !== 1'b1) begin
      $display("FAIL sat_lock actual=%0b required=1", s_locked); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      drive_s(1'b1, 6'h00, 1'b0);
      n_tests++;
      if (s_err_count !== exp_cnt[i] || s_err_pulse !== 1'b1) begin
        $display("FAIL sat_err%0d actual=%0d/%0b required=%0d/1", i, s_err_count, s_err_pulse, exp_cnt[i]);
        n_fail++;
      end
    end
    drive_s(1'b1, 6'h00, 1'b1);
    n_tests++;
    if (s_err_count !== 2'd0 || s_err_pulse !== 1'b1) begin
      $display("FAIL sat_clr_win actual=%0d/%0b required=0/1", s_err_count, s_err_pulse); n_fail++;
    end
    drive_s(1'b0, 6'h00, 1'b0);
    n_tests++;
    if (s_locked !== 1'b1 || s_err_pulse !== 1'b0) begin
      $display("FAIL sat_after actual=%0b/%0b required=1/0", s_locked, s_err_pulse); n_fail++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 6'h00;
    clr_err  = 1'b0;
    s_valid  = 1'b0;
    s_data   = 6'h00;
    s_clr    = 1'b0;
    test_reset;
    test_lock;
    test_single_error;
    test_unlock;
    test_gaps;
    test_reset_zero;
    test_clear;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
